// File: rtl/rx_pulse_guard.sv
// rx_pulse_guard: safety stage after serial_rx; max on-time, min off-time, link watchdog, sticky faults
// Ports:
//   clk         in   40 MHz system clock
//   res_n       in   synchronous active-low reset
//   raw_pls     in   recovered raw pulse from serial_rx
//   frame_stb   in   one-cycle strobe per valid decoded frame
//   sfp_loss    in   1 = no optical signal
//   max_on_sel  in   max-on select (3 bits), sampled at pulse start
//   fault_clr   in   one-cycle strobe clearing fault_code
//   pls         out  guarded gate-drive pulse
//   link_up     out  link-valid indication
//   fault_code  out  sticky faults: bit0 link lost while armed, bit1 on-time truncated
//   fault       out  |fault_code
module rx_pulse_guard #(
    parameter int MAX_ON_BASE = 400,
    parameter int MIN_OFF     = 800,
    parameter int LINK_TO     = 4000,
    parameter int LINK_UP_N   = 4
) (
    input  logic       clk,
    input  logic       res_n,
    input  logic       raw_pls,
    input  logic       frame_stb,
    input  logic       sfp_loss,
    input  logic [2:0] max_on_sel,
    input  logic       fault_clr,
    output logic       pls,
    output logic       link_up,
    output logic [1:0] fault_code,
    output logic       fault
);
    localparam int WD_W  = $clog2(LINK_TO + 1);
    localparam int OFF_W = $clog2(MIN_OFF + 2);
    localparam int UP_W  = $clog2(LINK_UP_N + 1);
    localparam logic [WD_W-1:0]  WD_MAX  = WD_W'(LINK_TO);
    localparam logic [OFF_W-1:0] OFF_MIN = OFF_W'(MIN_OFF);
    localparam logic [UP_W-1:0]  UP_N    = UP_W'(LINK_UP_N);

    typedef enum logic [1:0] {LINK_DOWN, IDLE, ON, OFF_HOLD} state_t;

    state_t            state, state_nxt;
    logic              raw_q, raw_q2;
    logic [WD_W-1:0]   wd;
    logic [UP_W-1:0]   up_cnt;
    logic [OFF_W-1:0]  off_cnt;
    logic [11:0]       on_cnt, max_on, max_on_calc;
    logic              rise, link_lost, pls_d, trunc, lost_set;

    assign rise        = raw_q & ~raw_q2;
    assign link_lost   = (wd == WD_MAX) | sfp_loss;
    assign max_on_calc = 12'(MAX_ON_BASE * (int'(max_on_sel) + 1));
    assign fault       = |fault_code;

    always_ff @(posedge clk) begin
        if (!res_n) state <= LINK_DOWN;
        else        state <= state_nxt;
    end

    // link loss overrides every other transition
    always_comb begin
        state_nxt = state;
        if (link_lost)
            state_nxt = LINK_DOWN;
        else
            case (state)
                LINK_DOWN: state_nxt = link_up ? OFF_HOLD : LINK_DOWN;
                IDLE:      state_nxt = rise ? ON : IDLE;
                ON:        state_nxt = (!raw_q || on_cnt == max_on) ? OFF_HOLD : ON;
                OFF_HOLD:  state_nxt = (off_cnt >= OFF_MIN) ? IDLE : OFF_HOLD;
                default:   state_nxt = LINK_DOWN;
            endcase
    end

    // pls is registered from state, but link loss kills it on the same edge the FSM leaves
    always_comb begin
        pls_d    = (state == ON) && !link_lost;
        trunc    = (state == ON) && raw_q && (on_cnt == max_on) && !link_lost;
        lost_set = (state != LINK_DOWN) && link_lost;
    end

    always_ff @(posedge clk) begin
        if (!res_n) begin
            raw_q      <= 1'b0;
            raw_q2     <= 1'b0;
            pls        <= 1'b0;
            link_up    <= 1'b0;
            fault_code <= 2'b00;
            wd         <= '0;
            up_cnt     <= '0;
            off_cnt    <= '0;
            on_cnt     <= '0;
            max_on     <= '0;
        end else begin
            raw_q      <= raw_pls;
            raw_q2     <= raw_q;
            pls        <= pls_d;
            wd         <= frame_stb ? '0 : (wd == WD_MAX ? wd : wd + 1'b1);
            up_cnt     <= link_lost ? '0 : ((frame_stb && up_cnt != UP_N) ? up_cnt + 1'b1 : up_cnt);
            link_up    <= !link_lost && (link_up || up_cnt == UP_N);
            // on_cnt holds 1 outside ON so it enters ON already counting the first cycle
            on_cnt     <= (state == ON) ? on_cnt + 1'b1 : 12'd1;
            off_cnt    <= (state == OFF_HOLD) ? off_cnt + 1'b1 : '0;
            max_on     <= (state == IDLE && rise) ? max_on_calc : max_on;
            // a coincident set event beats the clear
            fault_code <= (fault_clr ? 2'b00 : fault_code) | {trunc, lost_set};
        end
    end
endmodule

// File: tb/tb_rx_pulse_guard.sv
// tb_rx_pulse_guard: directed scenario bench for rx_pulse_guard
module tb_rx_pulse_guard;
    logic       clk = 1'b0;
    logic       res_n = 1'b0;
    logic       raw_pls = 1'b0;
    logic       frame_stb;
    logic       gen_stb = 1'b0;
    logic       man_stb = 1'b0;
    logic       stb_en = 1'b0;
    logic       sfp_loss = 1'b0;
    logic [2:0] max_on_sel = 3'd0;
    logic       fault_clr = 1'b0;
    logic       pls, link_up, fault;
    logic [1:0] fault_code;
    int         pass_cnt = 0;
    int         total = 0;

    assign frame_stb = gen_stb | man_stb;

    rx_pulse_guard dut (
        .clk(clk), .res_n(res_n), .raw_pls(raw_pls), .frame_stb(frame_stb),
        .sfp_loss(sfp_loss), .max_on_sel(max_on_sel), .fault_clr(fault_clr),
        .pls(pls), .link_up(link_up), .fault_code(fault_code), .fault(fault)
    );

    always #5 clk = ~clk;

    // background frame strobes every 1000 cycles while enabled
    initial begin
        int cnt;
        cnt = 0;
        forever begin
            @(negedge clk);
            cnt++;
            gen_stb = stb_en && (cnt % 1000 == 0);
        end
    end

    // raw pattern: up to three high windows; j counts negedges, raw set at j is sampled on the next posedge
    task automatic run_pattern(input logic [2:0] sel, input logic [2:0] sel_late,
                               input int a0, input int a1, input int b0, input int b1,
                               input int c0, input int c1, input int w,
                               output int first, output int second, output int hi, output int rises);
        logic prev;
        first = -1; second = -1; hi = 0; rises = 0; prev = 1'b0;
        max_on_sel = sel;
        for (int j = 0; j < w; j++) begin
            @(negedge clk);
            if (pls) begin
                hi++;
                if (!prev) begin
                    rises++;
                    if (first < 0) first = j;
                    else if (second < 0) second = j;
                end
            end
            prev = pls;
            if (j == 10) max_on_sel = sel_late;
            raw_pls = (j >= a0 && j < a1) || (j >= b0 && j < b1) || (j >= c0 && j < c1);
        end
    endtask

    task automatic test_reset;
        res_n = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (pls !== 1'b0) $display("FAIL reset_pls: got %b expected 0", pls); else pass_cnt++;
        total++; if (link_up !== 1'b0) $display("FAIL reset_link_up: got %b expected 0", link_up); else pass_cnt++;
        total++; if (fault_code !== 2'b00) $display("FAIL reset_fault_code: got %b expected 00", fault_code); else pass_cnt++;
        total++; if (fault !== 1'b0) $display("FAIL reset_fault: got %b expected 0", fault); else pass_cnt++;
        res_n = 1'b1;
    endtask

    task automatic test_link_up;
        for (int s = 0; s < 4; s++) begin
            man_stb = 1'b1;
            @(negedge clk);
            man_stb = 1'b0;
            total++; if (link_up !== 1'b0) $display("FAIL link_up_early_%0d: got %b expected 0", s, link_up); else pass_cnt++;
            if (s < 3) repeat (999) @(negedge clk);
        end
        @(negedge clk);
        total++; if (link_up !== 1'b1) $display("FAIL link_up_after_4th: got %b expected 1", link_up); else pass_cnt++;
        stb_en = 1'b1;
        repeat (1000) @(negedge clk);
        total++; if (pls !== 1'b0) $display("FAIL link_up_pls_idle: got %b expected 0", pls); else pass_cnt++;
    endtask

    task automatic test_basic_pulse;
        int first, second, hi, rises;
        run_pattern(3'd0, 3'd0, 0, 200, 0, 0, 0, 0, 1200, first, second, hi, rises);
        total++; if (first !== 3) $display("FAIL basic_delay: got %0d expected 3", first); else pass_cnt++;
        total++; if (hi !== 200) $display("FAIL basic_width: got %0d expected 200", hi); else pass_cnt++;
        total++; if (rises !== 1) $display("FAIL basic_rises: got %0d expected 1", rises); else pass_cnt++;
        total++; if (fault_code !== 2'b00) $display("FAIL basic_fault: got %b expected 00", fault_code); else pass_cnt++;
    endtask

    task automatic test_max_on;
        int first, second, hi, rises;
        run_pattern(3'd1, 3'd0, 0, 2000, 0, 0, 0, 0, 3000, first, second, hi, rises);
        total++; if (first !== 3) $display("FAIL maxon_delay: got %0d expected 3", first); else pass_cnt++;
        total++; if (hi !== 800) $display("FAIL maxon_width: got %0d expected 800", hi); else pass_cnt++;
        total++; if (rises !== 1) $display("FAIL maxon_refire: got %0d rises expected 1", rises); else pass_cnt++;
        total++; if (fault_code !== 2'b10) $display("FAIL maxon_fault: got %b expected 10", fault_code); else pass_cnt++;
        fault_clr = 1'b1;
        @(negedge clk);
        fault_clr = 1'b0;
        @(negedge clk);
        total++; if (fault_code !== 2'b00) $display("FAIL maxon_clear: got %b expected 00", fault_code); else pass_cnt++;
    endtask

    task automatic test_min_off;
        int first, second, hi, rises;
        run_pattern(3'd0, 3'd0, 0, 100, 200, 250, 1000, 1100, 2000, first, second, hi, rises);
        total++; if (first !== 3) $display("FAIL minoff_first: got %0d expected 3", first); else pass_cnt++;
        total++; if (second !== 1003) $display("FAIL minoff_second: got %0d expected 1003", second); else pass_cnt++;
        total++; if (rises !== 2) $display("FAIL minoff_rises: got %0d expected 2", rises); else pass_cnt++;
        total++; if (hi !== 200) $display("FAIL minoff_width: got %0d expected 200", hi); else pass_cnt++;
    endtask

    task automatic test_watchdog;
        stb_en = 1'b0;
        repeat (1100) @(negedge clk);
        man_stb = 1'b1;
        @(negedge clk);
        man_stb = 1'b0;
        repeat (999) @(negedge clk);
        max_on_sel = 3'd7;
        raw_pls = 1'b1;
        repeat (3001) @(negedge clk);
        total++; if (pls !== 1'b1) $display("FAIL wd_pls_before: got %b expected 1", pls); else pass_cnt++;
        total++; if (link_up !== 1'b1) $display("FAIL wd_link_before: got %b expected 1", link_up); else pass_cnt++;
        @(negedge clk);
        total++; if (pls !== 1'b0) $display("FAIL wd_pls_after: got %b expected 0", pls); else pass_cnt++;
        total++; if (link_up !== 1'b0) $display("FAIL wd_link_after: got %b expected 0", link_up); else pass_cnt++;
        total++; if (fault_code !== 2'b01) $display("FAIL wd_fault: got %b expected 01", fault_code); else pass_cnt++;
        fault_clr = 1'b1;
        @(negedge clk);
        fault_clr = 1'b0;
        raw_pls = 1'b0;
        total++; if (fault_code !== 2'b00 || fault !== 1'b0) $display("FAIL wd_clear: got %b/%b expected 00/0", fault_code, fault); else pass_cnt++;
    endtask

    task automatic test_sfp_and_reset;
        stb_en = 1'b1;
        for (int i = 0; i < 8000 && !link_up; i++) @(negedge clk);
        total++; if (link_up !== 1'b1) $display("FAIL relink1: got %b expected 1", link_up); else pass_cnt++;
        repeat (1000) @(negedge clk);
        max_on_sel = 3'd0;
        raw_pls = 1'b1;
        repeat (10) @(negedge clk);
        total++; if (pls !== 1'b1) $display("FAIL sfp_pls_before: got %b expected 1", pls); else pass_cnt++;
        sfp_loss = 1'b1;
        @(negedge clk);
        total++; if (pls !== 1'b0) $display("FAIL sfp_pls_after: got %b expected 0", pls); else pass_cnt++;
        total++; if (link_up !== 1'b0) $display("FAIL sfp_link: got %b expected 0", link_up); else pass_cnt++;
        total++; if (fault_code !== 2'b01) $display("FAIL sfp_fault: got %b expected 01", fault_code); else pass_cnt++;
        raw_pls = 1'b0;
        sfp_loss = 1'b0;
        for (int i = 0; i < 8000 && !link_up; i++) @(negedge clk);
        total++; if (link_up !== 1'b1) $display("FAIL relink2: got %b expected 1", link_up); else pass_cnt++;
        repeat (1000) @(negedge clk);
        raw_pls = 1'b1;
        repeat (10) @(negedge clk);
        total++; if (pls !== 1'b1) $display("FAIL rst_pls_before: got %b expected 1", pls); else pass_cnt++;
        res_n = 1'b0;
        @(negedge clk);
        total++; if ({pls, link_up, fault_code, fault} !== 5'b0)
            $display("FAIL rst_mid_pulse: got pls=%b link=%b code=%b fault=%b expected all 0", pls, link_up, fault_code, fault);
        else pass_cnt++;
        res_n = 1'b1;
        raw_pls = 1'b0;
    endtask

    initial begin
        test_reset;
        test_link_up;
        test_basic_pulse;
        test_max_on;
        test_min_off;
        test_watchdog;
        test_sfp_and_reset;
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
